// File: rtl/trace_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_monitor_if
// Description : Retirement, breakpoint, run-control and trace readout signals
//               shared between the core side and trace_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_monitor_if #(
    parameter int DEPTH = 16,
    parameter int NBP   = 2
);
    logic                   valid;
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic [32*NBP-1:0]      bp_addr;
    logic [NBP-1:0]         bp_en;
    logic                   halt_req;
    logic                   resume;
    logic                   rd_en;
    logic                   run;
    logic                   halted;
    logic [1:0]             halt_cause;
    logic [NBP-1:0]         bp_hit;
    logic [31:0]            cycle_cnt;
    logic [$clog2(DEPTH):0] trace_count;
    logic                   rd_valid;
    logic [31:0]            rd_pc;
    logic [31:0]            rd_instr;

    modport master (
        output valid, pc, instr, bp_addr, bp_en, halt_req, resume, rd_en,
        input  run, halted, halt_cause, bp_hit, cycle_cnt, trace_count,
               rd_valid, rd_pc, rd_instr
    );

    modport slave (
        input  valid, pc, instr, bp_addr, bp_en, halt_req, resume, rd_en,
        output run, halted, halt_cause, bp_hit, cycle_cnt, trace_count,
               rd_valid, rd_pc, rd_instr
    );
endinterface
`default_nettype wire

// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : trace_monitor
// Description : Run-control and circular retirement trace for the RISC-V core;
//               halts on breakpoint, timeout or request, then reads out.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_monitor #(
    parameter int DEPTH      = 16,
    parameter int NBP        = 2,
    parameter int MAX_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    trace_monitor_if.slave bus
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    localparam logic [C_CNT_W-1:0] C_DEPTH      = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE    = C_PTR_W'(1);
    localparam logic [31:0]        C_LAST_CYCLE = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]        C_CYC_ONE    = 32'd1;

    localparam logic [0:0] C_ST_RUN  = 1'b0;
    localparam logic [0:0] C_ST_HALT = 1'b1;

    localparam logic [1:0] C_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] C_CAUSE_BP      = 2'b01;
    localparam logic [1:0] C_CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] C_CAUSE_MANUAL  = 2'b11;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [31:0]        r_cycle_cnt;
    logic [1:0]         r_halt_cause;
    logic [NBP-1:0]     r_bp_hit;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_trace_count;
    logic               r_rd_valid;
    logic [31:0]        r_rd_pc;
    logic [31:0]        r_rd_instr;
    logic [63:0]        r_mem [DEPTH];

    logic [NBP-1:0]     w_bp_match;
    logic               w_any_bp;
    logic               w_timeout;
    logic               w_in_run;
    logic               w_halt_evt;
    logic               w_resume;
    logic               w_pop;
    logic               w_wr;
    logic [1:0]         w_cause;
    logic [63:0]        w_rd_entry;

    for (genvar k = 0; k < NBP; k++) begin : g_bp
        assign w_bp_match[k] = bus.valid && bus.bp_en[k] &&
                               (bus.pc == bus.bp_addr[32*k +: 32]);
    end

    assign w_in_run   = (r_state == C_ST_RUN);
    assign w_any_bp   = |w_bp_match;
    assign w_timeout  = (r_cycle_cnt == C_LAST_CYCLE);
    assign w_halt_evt = w_any_bp || w_timeout || bus.halt_req;
    assign w_resume   = !w_in_run && bus.resume;
    assign w_pop      = !w_in_run && !bus.resume && bus.rd_en &&
                        (r_trace_count != '0);
    assign w_wr       = !rst && w_in_run && bus.valid;
    assign w_rd_entry = r_mem[r_rd_ptr];

    always_comb begin
        w_cause = C_CAUSE_NONE;
        if (w_any_bp)
            w_cause = C_CAUSE_BP;
        else if (w_timeout)
            w_cause = C_CAUSE_TIMEOUT;
        else if (bus.halt_req)
            w_cause = C_CAUSE_MANUAL;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= C_ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_RUN:  if (w_halt_evt) w_state_nxt = C_ST_HALT;
            default:   if (bus.resume) w_state_nxt = C_ST_RUN;
        endcase
    end

    // Trace storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {bus.pc, bus.instr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_halt_cause  <= C_CAUSE_NONE;
            r_bp_hit      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_trace_count <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_pc       <= '0;
            r_rd_instr    <= '0;
        end else if (w_resume) begin
            r_cycle_cnt   <= '0;
            r_halt_cause  <= C_CAUSE_NONE;
            r_bp_hit      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_trace_count <= '0;
            r_rd_valid    <= 1'b0;
        end else if (w_in_run) begin
            r_cycle_cnt <= r_cycle_cnt + C_CYC_ONE;
            r_rd_valid  <= 1'b0;
            if (w_any_bp)
                r_bp_hit <= w_bp_match;
            if (w_halt_evt)
                r_halt_cause <= w_cause;
            if (bus.valid) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                // A full buffer drops its oldest entry by dragging the read pointer along.
                if (r_trace_count == C_DEPTH)
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                else
                    r_trace_count <= r_trace_count + C_CNT_ONE;
            end
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_pc       <= w_rd_entry[63:32];
                r_rd_instr    <= w_rd_entry[31:0];
                r_rd_ptr      <= r_rd_ptr + C_PTR_ONE;
                r_trace_count <= r_trace_count - C_CNT_ONE;
            end
        end
    end

    assign bus.run         = w_in_run;
    assign bus.halted      = !w_in_run;
    assign bus.halt_cause  = r_halt_cause;
    assign bus.bp_hit      = r_bp_hit;
    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.trace_count = r_trace_count;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_pc       = r_rd_pc;
    assign bus.rd_instr    = r_rd_instr;
endmodule
`default_nettype wire

// File: tb/tb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_monitor
// Description : Directed self-checking bench for trace_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_monitor;
    localparam int DEPTH      = 16;
    localparam int NBP        = 2;
    localparam int MAX_CYCLES = 1000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    trace_monitor_if #(.DEPTH(DEPTH), .NBP(NBP)) bus ();

    trace_monitor #(
        .DEPTH      (DEPTH),
        .NBP        (NBP),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valid    = 1'b0;
        bus.pc       = '0;
        bus.instr    = '0;
        bus.bp_addr  = '0;
        bus.bp_en    = '0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.run !== 1'b1) $display("FAIL reset_run: got %b expected 1", bus.run); else passed++;
        checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", bus.halted); else passed++;
        checks++; if (bus.halt_cause !== 2'b00) $display("FAIL reset_cause: got %b expected 00", bus.halt_cause); else passed++;
        checks++; if (bus.bp_hit !== 2'b00) $display("FAIL reset_bp_hit: got %b expected 00", bus.bp_hit); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt); else passed++;
        checks++; if (bus.trace_count !== 5'd0) $display("FAIL reset_trace_count: got %0d expected 0", bus.trace_count); else passed++;
        checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); else passed++;
        checks++; if (bus.rd_pc !== 32'd0 || bus.rd_instr !== 32'd0)
            $display("FAIL reset_rd_data: got %h/%h expected 0/0", bus.rd_pc, bus.rd_instr); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_breakpoint();
        logic [31:0] exp_pc;
        bus.bp_addr[31:0] = 32'h3c;
        bus.bp_en         = 2'b01;
        for (int i = 0; i < 16; i++) begin
            bus.valid = 1'b1;
            bus.pc    = 32'(i * 4);
            bus.instr = ~32'(i * 4);
            step();
            if (i == 14) begin
                checks++; if (bus.run !== 1'b1 || bus.cycle_cnt !== 32'd15)
                    $display("FAIL bp_pre_halt: got run=%b cnt=%0d expected run=1 cnt=15", bus.run, bus.cycle_cnt); else passed++;
            end
        end
        bus.valid = 1'b0;
        checks++; if (bus.halted !== 1'b1 || bus.run !== 1'b0)
            $display("FAIL bp_halted: got halted=%b run=%b expected 1/0", bus.halted, bus.run); else passed++;
        checks++; if (bus.halt_cause !== 2'b01) $display("FAIL bp_cause: got %b expected 01", bus.halt_cause); else passed++;
        checks++; if (bus.bp_hit !== 2'b01) $display("FAIL bp_hit: got %b expected 01", bus.bp_hit); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd16) $display("FAIL bp_cycle_cnt: got %0d expected 16", bus.cycle_cnt); else passed++;
        checks++; if (bus.trace_count !== 5'd16) $display("FAIL bp_trace_count: got %0d expected 16", bus.trace_count); else passed++;

        // Retirements while halted must be ignored and the counter must hold.
        bus.valid = 1'b1;
        bus.pc    = 32'h999;
        step();
        bus.valid = 1'b0;
        checks++; if (bus.trace_count !== 5'd16 || bus.cycle_cnt !== 32'd16)
            $display("FAIL bp_halt_hold: got cnt=%0d trace=%0d expected 16/16", bus.cycle_cnt, bus.trace_count); else passed++;

        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_pc = 32'(i * 4);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc || bus.rd_instr !== ~exp_pc)
                $display("FAIL bp_pop%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, bus.rd_valid, bus.rd_pc, bus.rd_instr, exp_pc, ~exp_pc); else passed++;
        end
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.trace_count !== 5'd0 || bus.rd_pc !== 32'h3c)
            $display("FAIL bp_pop_empty: got v=%b trace=%0d pc=%h expected v=0 trace=0 pc=3c",
                     bus.rd_valid, bus.trace_count, bus.rd_pc); else passed++;

        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        bus.bp_en  = 2'b00;
        checks++; if (bus.run !== 1'b1 || bus.cycle_cnt !== 32'd0 || bus.halt_cause !== 2'b00 || bus.bp_hit !== 2'b00)
            $display("FAIL bp_resume: got run=%b cnt=%0d cause=%b hit=%b expected 1/0/00/00",
                     bus.run, bus.cycle_cnt, bus.halt_cause, bus.bp_hit); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        for (int i = 0; i < 20; i++) begin
            bus.valid = 1'b1;
            bus.pc    = 32'(i * 4);
            bus.instr = ~32'(i * 4);
            step();
        end
        bus.valid    = 1'b0;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        checks++; if (bus.halt_cause !== 2'b11) $display("FAIL ovf_cause: got %b expected 11", bus.halt_cause); else passed++;
        checks++; if (bus.trace_count !== 5'd16) $display("FAIL ovf_trace_count: got %0d expected 16", bus.trace_count); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd21 || bus.bp_hit !== 2'b00)
            $display("FAIL ovf_cnt_hit: got cnt=%0d hit=%b expected 21/00", bus.cycle_cnt, bus.bp_hit); else passed++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_pc = 32'h10 + 32'(i * 4);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp_pc)
                $display("FAIL ovf_pop%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.rd_valid, bus.rd_pc, exp_pc); else passed++;
        end
        bus.rd_en  = 1'b0;
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < MAX_CYCLES; i++) begin
            bus.valid    = 1'b1;
            bus.pc       = 32'(i * 4);
            bus.instr    = ~32'(i * 4);
            bus.halt_req = (i == MAX_CYCLES - 1);
            step();
            if (i == MAX_CYCLES - 2) begin
                checks++; if (bus.run !== 1'b1 || bus.cycle_cnt !== 32'd999)
                    $display("FAIL to_pre_halt: got run=%b cnt=%0d expected 1/999", bus.run, bus.cycle_cnt); else passed++;
            end
        end
        bus.valid    = 1'b0;
        bus.halt_req = 1'b0;
        checks++; if (bus.halted !== 1'b1) $display("FAIL to_halted: got %b expected 1", bus.halted); else passed++;
        checks++; if (bus.halt_cause !== 2'b10) $display("FAIL to_cause: got %b expected 10", bus.halt_cause); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd1000) $display("FAIL to_cycle_cnt: got %0d expected 1000", bus.cycle_cnt); else passed++;
        checks++; if (bus.trace_count !== 5'd16) $display("FAIL to_trace_count: got %0d expected 16", bus.trace_count); else passed++;
        step();
        checks++; if (bus.cycle_cnt !== 32'd1000) $display("FAIL to_cnt_hold: got %0d expected 1000", bus.cycle_cnt); else passed++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'hf60)
            $display("FAIL to_oldest: got v=%b pc=%h expected v=1 pc=f60", bus.rd_valid, bus.rd_pc); else passed++;
    endtask

    task automatic test_resume_vs_read();
        bus.rd_en  = 1'b1;
        bus.resume = 1'b1;
        step();
        bus.rd_en  = 1'b0;
        bus.resume = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) $display("FAIL rvr_rd_valid: got %b expected 0", bus.rd_valid); else passed++;
        checks++; if (bus.run !== 1'b1) $display("FAIL rvr_run: got %b expected 1", bus.run); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd0 || bus.trace_count !== 5'd0 || bus.halt_cause !== 2'b00)
            $display("FAIL rvr_cleared: got cnt=%0d trace=%0d cause=%b expected 0/0/00",
                     bus.cycle_cnt, bus.trace_count, bus.halt_cause); else passed++;
        bus.valid = 1'b1;
        bus.pc    = 32'h80;
        bus.instr = 32'h13;
        step();
        bus.valid = 1'b0;
        checks++; if (bus.trace_count !== 5'd1 || bus.cycle_cnt !== 32'd1)
            $display("FAIL rvr_first_retire: got trace=%0d cnt=%0d expected 1/1", bus.trace_count, bus.cycle_cnt); else passed++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.trace_count !== 5'd1)
            $display("FAIL rvr_rd_in_run: got v=%b trace=%0d expected 0/1", bus.rd_valid, bus.trace_count); else passed++;
    endtask

    task automatic test_simultaneous();
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        bus.resume   = 1'b1;
        step();
        bus.resume   = 1'b0;
        repeat (MAX_CYCLES - 16) step();
        // Comparator 0 matches 0x20 mid-run but is disabled.
        bus.bp_addr = {32'h3c, 32'h20};
        bus.bp_en   = 2'b10;
        for (int i = 0; i < 16; i++) begin
            bus.valid    = 1'b1;
            bus.pc       = 32'(i * 4);
            bus.instr    = ~32'(i * 4);
            bus.halt_req = (i == 15);
            step();
            if (i == 14) begin
                checks++; if (bus.run !== 1'b1 || bus.cycle_cnt !== 32'd999)
                    $display("FAIL sim_pre_halt: got run=%b cnt=%0d expected 1/999", bus.run, bus.cycle_cnt); else passed++;
            end
        end
        bus.valid    = 1'b0;
        bus.halt_req = 1'b0;
        checks++; if (bus.halt_cause !== 2'b01) $display("FAIL sim_cause: got %b expected 01", bus.halt_cause); else passed++;
        checks++; if (bus.bp_hit !== 2'b10) $display("FAIL sim_bp_hit: got %b expected 10", bus.bp_hit); else passed++;
        checks++; if (bus.cycle_cnt !== 32'd1000 || bus.trace_count !== 5'd16)
            $display("FAIL sim_counts: got cnt=%0d trace=%0d expected 1000/16", bus.cycle_cnt, bus.trace_count); else passed++;
    endtask

    task automatic test_reset_mid_readout();
        bus.bp_en = 2'b00;
        bus.rd_en = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h08 || bus.trace_count !== 5'd13)
            $display("FAIL rmr_third_pop: got v=%b pc=%h trace=%0d expected 1/08/13",
                     bus.rd_valid, bus.rd_pc, bus.trace_count); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rd_en = 1'b0;
        checks++; if ({bus.run, bus.halted, bus.halt_cause, bus.bp_hit, bus.cycle_cnt, bus.trace_count,
                       bus.rd_valid, bus.rd_pc, bus.rd_instr} !== {1'b1, 1'b0, 2'b00, 2'b00, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0})
            $display("FAIL rmr_reset_values: got run=%b halted=%b cause=%b hit=%b cnt=%0d trace=%0d v=%b pc=%h instr=%h",
                     bus.run, bus.halted, bus.halt_cause, bus.bp_hit, bus.cycle_cnt, bus.trace_count,
                     bus.rd_valid, bus.rd_pc, bus.rd_instr); else passed++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.run !== 1'b1)
            $display("FAIL rmr_rd_run: got v=%b run=%b expected 0/1", bus.rd_valid, bus.run); else passed++;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        bus.rd_en    = 1'b1;
        step();
        bus.rd_en    = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'd0 || bus.halted !== 1'b1 || bus.halt_cause !== 2'b11)
            $display("FAIL rmr_rd_empty: got v=%b pc=%h halted=%b cause=%b expected 0/0/1/11",
                     bus.rd_valid, bus.rd_pc, bus.halted, bus.halt_cause); else passed++;
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_overflow();
        test_timeout();
        test_resume_vs_read();
        test_simultaneous();
        test_reset_mid_readout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
